// File: rtl/tff_bank_scheduler.sv
// tff_bank_scheduler: round-robin arbiter that shares one WIDTH-bit bank of
// toggle flip-flops among NREQ requesters. A winner's mask is latched in GRANT
// and toggled into the bank in APPLY, which also carries a one-cycle ack.
// Optional build macro TFF_SCHED_BURST_EN: APPLY may chain straight into the
// next GRANT when other requests are pending (one operation every 2 cycles).
module tff_bank_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int PTRW = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   mask,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         ack,
  output logic                    busy,
  output logic [WIDTH-1:0]        q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [PTRW-1:0]   ptr_reg;
  logic [PTRW-1:0]   win_reg, win_next;
  logic [WIDTH-1:0]  mask_reg;
  logic [WIDTH-1:0]  q_reg;
  logic              load_win;
  logic [NREQ-1:0]   win_onehot;
  logic [NREQ-1:0]   req_eff;
  logic [WIDTH-1:0]  mask_sel;
  logic [PTRW-1:0]   ptr_inc;

  // One-hot decode of the registered winner
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_dec
      assign win_onehot[gi] = (win_reg == PTRW'(gi));
    end
  endgenerate

  assign busy  = (state_reg != IDLE);
  assign grant = busy ? win_onehot : '0;
  assign ack   = (state_reg == APPLY) ? win_onehot : '0;

  // During APPLY the bank output already shows the toggled value so that q and
  // ack become visible together; q_reg commits the same value as APPLY ends.
  assign q = (state_reg == APPLY) ? (q_reg ^ mask_reg) : q_reg;

  // The requester being acked this cycle never competes for the next grant
  assign req_eff  = req & ~ack;
  assign mask_sel = mask[win_reg*WIDTH +: WIDTH];
  assign ptr_inc  = (win_reg == PTRW'(NREQ-1)) ? '0 : win_reg + 1'b1;

  // Round-robin search: first set request at or above the pointer, wrapping
  always_comb begin
    logic             found;
    logic [PTRW:0]    sum;
    found    = 1'b0;
    sum      = '0;
    win_next = ptr_reg;
    for (int off = 0; off < NREQ; off++) begin
      sum = {1'b0, ptr_reg} + (PTRW+1)'(off);
      if (sum >= (PTRW+1)'(NREQ)) begin
        sum = sum - (PTRW+1)'(NREQ);
      end
      if (!found && req_eff[sum[PTRW-1:0]]) begin
        found    = 1'b1;
        win_next = sum[PTRW-1:0];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    load_win   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req_eff) begin
          state_next = GRANT;
          load_win   = 1'b1;
        end
      end
      GRANT: begin
        state_next = APPLY;
      end
      APPLY: begin
`ifdef TFF_SCHED_BURST_EN
        if (|req_eff) begin
          state_next = GRANT;
          load_win   = 1'b1;
        end else begin
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, winner, latched mask, pointer and toggle bank registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      win_reg   <= '0;
      mask_reg  <= '0;
      q_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (load_win) begin
        win_reg <= win_next;
      end
      // Pointer advances on entry to APPLY so a chained arbitration from APPLY
      // already sees the rotated priority.
      if (state_reg == GRANT) begin
        mask_reg <= mask_sel;
        ptr_reg  <= ptr_inc;
      end
      if (state_reg == APPLY) begin
        q_reg <= q_reg ^ mask_reg;
      end
    end
  end

endmodule
